// File: rtl/abc_input_debouncer_if.sv
// Board-switch side and conditioned A/B/C side of the input debouncer.
// The master drives the raw switches; the slave (the debouncer) drives the clean levels.
interface abc_input_debouncer_if;
  logic [2:0] sw_in;
  logic       a_out;
  logic       b_out;
  logic       c_out;
  logic       change_strobe;

  modport master (
    output sw_in,
    input  a_out,
    input  b_out,
    input  c_out,
    input  change_strobe
  );

  modport slave (
    input  sw_in,
    output a_out,
    output b_out,
    output c_out,
    output change_strobe
  );
endinterface

// File: rtl/abc_input_debouncer.sv
// Synchronizes and debounces three raw switch inputs (A, B, C) into clean levels,
// with a one-cycle strobe on any output change.
module abc_input_debouncer #(
  parameter int CNT_MAX = 1000000,
  parameter int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  abc_input_debouncer_if.slave  io
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } bit_state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       sync1_q, sync1_d;
  logic [2:0]       sync2_q, sync2_d;
  logic [2:0]       deb_q,   deb_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic             strobe_q, strobe_d;
  bit_state_e       state_s [3];

  // A bit counts while its synchronized input disagrees with the debounced level;
  // agreement at any edge discards the partial count.
  always_comb begin
    sync1_d  = io.sw_in;
    sync2_d  = sync1_q;
    deb_d    = deb_q;
    strobe_d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i]   = cnt_q[i];
      state_s[i] = (sync2_q[i] != deb_q[i]) ? ST_COUNT : ST_IDLE;
      case (state_s[i])
        ST_IDLE: begin
          cnt_d[i] = '0;
        end
        ST_COUNT: begin
          if (cnt_q[i] == CNT_LAST) begin
            deb_d[i] = sync2_q[i];
            cnt_d[i] = '0;
            strobe_d = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          cnt_d[i] = '0;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 3'b000;
      sync2_q  <= 3'b000;
      deb_q    <= 3'b000;
      strobe_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      deb_q    <= deb_d;
      strobe_q <= strobe_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign io.a_out         = deb_q[2];
  assign io.b_out         = deb_q[1];
  assign io.c_out         = deb_q[0];
  assign io.change_strobe = strobe_q;

endmodule
